// File: rtl/sysid_boot_checker.sv
// Avalon-MM master that reads the sysid ID and timestamp words after reset or on request,
// compares them against expected values and holds sticky pass/fail/timeout flags.
module sysid_boot_checker #(
   parameter logic [31:0] EXPECTED_ID        = 32'd0,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1530972499,
   parameter int unsigned TIMEOUT_CYCLES     = 255,
   parameter int unsigned MAX_RETRIES        = 3,
   parameter bit          AUTO_START         = 1'b1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic        avm_readdatavalid,
   input  logic [31:0] avm_readdata,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout_err,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   localparam logic [15:0] T_LAST = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]  R_MAX  = 4'(MAX_RETRIES);

   typedef enum logic [2:0] {
      IDLE,
      REQ_ID,
      WAIT_ID,
      REQ_TS,
      WAIT_TS,
      FINISH
   } state_t;

   state_t      state;
   logic [15:0] tcnt;
   logic [3:0]  retry;
   logic        id_got;
   logic        ts_got;
   logic        auto_pend;

   logic        in_req;
   logic        is_ts;
   logic        in_xfer;
   logic        got;

   always_comb begin
      in_req  = (state == REQ_ID) || (state == REQ_TS);
      is_ts   = (state == REQ_TS) || (state == WAIT_TS);
      in_xfer = in_req || (state == WAIT_ID) || (state == WAIT_TS);
      // In a REQ state, data only counts on the accept cycle (zero-latency slave)
      got     = in_xfer && avm_readdatavalid && (!in_req || !avm_waitrequest);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         avm_read    <= 1'b0;
         avm_address <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         id_ok       <= 1'b0;
         ts_ok       <= 1'b0;
         timeout_err <= 1'b0;
         id_value    <= '0;
         ts_value    <= '0;
         tcnt        <= '0;
         retry       <= '0;
         id_got      <= 1'b0;
         ts_got      <= 1'b0;
         auto_pend   <= AUTO_START;
      end else begin
         case (state)
            IDLE: begin
               if (start || auto_pend) begin
                  auto_pend   <= 1'b0;
                  busy        <= 1'b1;
                  done        <= 1'b0;
                  id_ok       <= 1'b0;
                  ts_ok       <= 1'b0;
                  timeout_err <= 1'b0;
                  id_got      <= 1'b0;
                  ts_got      <= 1'b0;
                  tcnt        <= '0;
                  retry       <= '0;
                  avm_read    <= 1'b1;
                  avm_address <= 1'b0;
                  state       <= REQ_ID;
               end
            end

            REQ_ID, WAIT_ID, REQ_TS, WAIT_TS: begin
               if (got) begin
                  if (is_ts) begin
                     ts_value <= avm_readdata;
                     ts_got   <= 1'b1;
                     avm_read <= 1'b0;
                     state    <= FINISH;
                  end else begin
                     id_value    <= avm_readdata;
                     id_got      <= 1'b1;
                     avm_read    <= 1'b1;
                     avm_address <= 1'b1;
                     tcnt        <= '0;
                     retry       <= '0;
                     state       <= REQ_TS;
                  end
               end else if (tcnt == T_LAST) begin
                  if (retry < R_MAX) begin
                     retry    <= retry + 4'd1;
                     tcnt     <= '0;
                     avm_read <= 1'b1;
                     if (is_ts) state <= REQ_TS;
                     else       state <= REQ_ID;
                  end else begin
                     timeout_err <= 1'b1;
                     avm_read    <= 1'b0;
                     state       <= FINISH;
                  end
               end else begin
                  tcnt <= tcnt + 16'd1;
                  if (in_req && !avm_waitrequest) begin
                     avm_read <= 1'b0;
                     if (is_ts) state <= WAIT_TS;
                     else       state <= WAIT_ID;
                  end
               end
            end

            FINISH: begin
               // A word that was never captured cannot pass, whatever its register holds
               id_ok       <= id_got && (id_value == EXPECTED_ID);
               ts_ok       <= ts_got && (ts_value == EXPECTED_TIMESTAMP);
               done        <= 1'b1;
               busy        <= 1'b0;
               avm_address <= 1'b0;
               state       <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Randomized self-checking bench for sysid_boot_checker: a scripted Avalon slave plus a
// per-word attempt model that predicts outcome, captured values, read count and busy time.
module tb_sysid_boot_checker;

   localparam logic [31:0] EXP_ID = 32'd0;
   localparam logic [31:0] EXP_TS = 32'd1530972499;
   localparam int          T      = 8;
   localparam int          R      = 2;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        start;
   logic        avm_address;
   logic        avm_read;
   logic        avm_waitrequest;
   logic        avm_readdatavalid;
   logic [31:0] avm_readdata;
   logic        busy, done, id_ok, ts_ok, timeout_err;
   logic [31:0] id_value, ts_value;

   always #5 clock = ~clock;

   sysid_boot_checker #(
      .EXPECTED_ID       (EXP_ID),
      .EXPECTED_TIMESTAMP(EXP_TS),
      .TIMEOUT_CYCLES    (T),
      .MAX_RETRIES       (R),
      .AUTO_START        (1'b1)
   ) dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .start            (start),
      .avm_address      (avm_address),
      .avm_read         (avm_read),
      .avm_waitrequest  (avm_waitrequest),
      .avm_readdatavalid(avm_readdatavalid),
      .avm_readdata     (avm_readdata),
      .busy             (busy),
      .done             (done),
      .id_ok            (id_ok),
      .ts_ok            (ts_ok),
      .timeout_err      (timeout_err),
      .id_value         (id_value),
      .ts_value         (ts_value)
   );

   // One slave attempt: stall cycles, response latency after accept (-1 = never), payload
   typedef struct {
      int          w;
      int          lat;
      logic [31:0] data;
   } att_t;

   att_t        q0[$];
   att_t        q1[$];
   int          reads0, reads1;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] m_id, m_ts;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic push(input bit addr, input int w, input int lat, input logic [31:0] data);
      att_t a;
      a.w = w; a.lat = lat; a.data = data;
      if (addr) q1.push_back(a);
      else      q0.push_back(a);
   endtask

   // Slave model and bus-hold monitor
   initial begin
      att_t        cur;
      int          sw, pend;
      bit          sl_busy, prev_stall, prev_addr;
      logic [31:0] pend_data;
      avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
      sl_busy = 0; pend = 0; sw = 0; prev_stall = 0; prev_addr = 0; pend_data = '0;
      cur.w = 0; cur.lat = -1; cur.data = '0;
      forever begin
         @(posedge clock); #1;
         avm_readdatavalid = 1'b0;
         avm_readdata      = $urandom;
         if (!reset_n) begin
            sl_busy = 0; pend = 0; prev_stall = 0; avm_waitrequest = 1'b0;
            continue;
         end
         if (prev_stall) begin
            check_eq("rd_hold", {31'd0, avm_read}, 32'd1);
            check_eq("addr_hold", {31'd0, avm_address}, {31'd0, prev_addr});
         end
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin avm_readdatavalid = 1'b1; avm_readdata = pend_data; end
         end
         if (avm_read && !sl_busy) begin
            cur.w = 0; cur.lat = -1; cur.data = '0;
            if (avm_address) begin if (q1.size() > 0) cur = q1.pop_front(); end
            else             begin if (q0.size() > 0) cur = q0.pop_front(); end
            sl_busy = 1; sw = cur.w;
         end
         if (sl_busy) begin
            if (sw > 0) begin
               avm_waitrequest = 1'b1; sw--;
            end else begin
               avm_waitrequest = 1'b0; sl_busy = 0;
               if (avm_address) reads1++; else reads0++;
               if (cur.lat == 0) begin avm_readdatavalid = 1'b1; avm_readdata = cur.data; end
               else if (cur.lat > 0) begin pend = cur.lat; pend_data = cur.data; end
            end
         end else begin
            avm_waitrequest = 1'($urandom % 2);
            // Stray valid while idle must be ignored
            if (!busy && pend == 0) avm_readdatavalid = 1'($urandom % 2);
         end
         prev_stall = avm_read && avm_waitrequest;
         prev_addr  = avm_address;
      end
   end

   // Outcome of one word: tries up to R+1 attempts, each lasting w+lat+1 cycles on
   // success or T cycles when the response would land at or beyond the deadline
   function automatic void word_model(input bit addr, output bit ok, output logic [31:0] val,
                                      output int cyc, output int used);
      att_t a;
      ok = 0; val = '0; cyc = 0; used = 0;
      for (int k = 0; k <= R; k++) begin
         a.w = 0; a.lat = -1; a.data = '0;
         if (addr) begin if (k < q1.size()) a = q1[k]; end
         else      begin if (k < q0.size()) a = q0[k]; end
         used++;
         if (a.lat >= 0 && a.w + a.lat < T) begin
            ok = 1; val = a.data; cyc += a.w + a.lat + 1;
            return;
         end
         cyc += T;
      end
   endfunction

   task automatic check_reset(input string p);
      check_eq({p, "_read"}, {31'd0, avm_read}, 32'd0);
      check_eq({p, "_addr"}, {31'd0, avm_address}, 32'd0);
      check_eq({p, "_busy"}, {31'd0, busy}, 32'd0);
      check_eq({p, "_flags"}, {28'd0, done, id_ok, ts_ok, timeout_err}, 32'd0);
      check_eq({p, "_idv"}, id_value, 32'd0);
      check_eq({p, "_tsv"}, ts_value, 32'd0);
   endtask

   task automatic run_seq(input bit via_reset, input bit poke_start);
      bit          g0, g1;
      logic [31:0] v0, v1, e_id, e_ts;
      int          c0, c1, u0, u1, cyc, n;
      word_model(1'b0, g0, v0, c0, u0);
      g1 = 0; v1 = '0; c1 = 0; u1 = 0;
      if (g0) word_model(1'b1, g1, v1, c1, u1);
      cyc  = c0 + c1 + 1;
      e_id = g0 ? v0 : m_id;
      e_ts = g1 ? v1 : m_ts;
      reads0 = 0; reads1 = 0;
      if (via_reset) reset_n = 1'b1;
      else           start   = 1'b1;
      @(posedge clock); #2;
      start = 1'b0;
      check_eq("start_busy", {31'd0, busy}, 32'd1);
      check_eq("start_clr", {28'd0, done, id_ok, ts_ok, timeout_err}, 32'd0);
      n = 0;
      while (busy && n < 400) begin
         n++;
         start = poke_start && (n == 2);
         @(posedge clock); #2;
      end
      start = 1'b0;
      check_eq("busy_cycles", n, cyc);
      check_eq("done", {31'd0, done}, 32'd1);
      check_eq("id_ok", {31'd0, id_ok}, {31'd0, g0 && (v0 == EXP_ID)});
      check_eq("ts_ok", {31'd0, ts_ok}, {31'd0, g1 && (v1 == EXP_TS)});
      check_eq("timeout_err", {31'd0, timeout_err}, {31'd0, !(g0 && g1)});
      check_eq("id_value", id_value, e_id);
      check_eq("ts_value", ts_value, e_ts);
      check_eq("reads_addr0", reads0, u0);
      check_eq("reads_addr1", reads1, u1);
      m_id = e_id; m_ts = e_ts;
      q0.delete(); q1.delete();
      repeat (2) @(posedge clock);
      #2;
   endtask

   initial begin
      int n;
      reset_n = 1'b0; start = 1'b0; m_id = '0; m_ts = '0;
      repeat (3) @(posedge clock);
      #2;
      check_reset("por");

      // Auto-start after reset, zero-latency slave
      push(0, 0, 0, EXP_ID); push(1, 0, 0, EXP_TS);
      run_seq(1, 0);
      // Timestamp off by one
      push(0, 0, 0, EXP_ID); push(1, 0, 0, EXP_TS + 32'd1);
      run_seq(0, 0);
      // Four-cycle stall, two-cycle response latency
      push(0, 4, 2, EXP_ID); push(1, 4, 2, EXP_TS);
      run_seq(0, 0);
      // ID never answered: retries exhausted, timestamp never requested
      repeat (3) push(0, 0, -1, EXP_ID);
      run_seq(0, 0);
      // Start while busy is ignored, then a fresh start after done
      push(0, 2, 1, EXP_ID); push(1, 1, 3, EXP_TS);
      run_seq(0, 1);
      push(0, 0, 0, EXP_ID); push(1, 0, 0, EXP_TS);
      run_seq(0, 0);
      // Late bad data lands during the retry's stall and must be discarded
      push(0, 0, 9, 32'hDEADBEEF); push(0, 3, 1, EXP_ID); push(1, 0, 1, EXP_TS);
      run_seq(0, 0);

      for (int s = 0; s < 30; s++) begin
         for (int a = 0; a < 2; a++) begin
            for (int k = 0; k <= R; k++) begin
               int          lat;
               logic [31:0] d;
               lat = ($urandom % 4 == 0) ? -1 : int'($urandom % 4);
               d   = (a == 0) ? EXP_ID : EXP_TS;
               if ($urandom % 3 == 0) d = $urandom;
               push(a[0], int'($urandom % 5), lat, d);
            end
         end
         run_seq(0, 1'($urandom % 2));
      end

      // Reset asserted while waiting for the timestamp
      push(0, 0, 0, EXP_ID); push(1, 0, -1, EXP_TS);
      start = 1'b1;
      @(posedge clock); #2;
      start = 1'b0;
      n = 0;
      while (!(busy && avm_address && !avm_read) && n < 50) begin
         n++;
         @(posedge clock); #2;
      end
      if (n >= 50) check_eq("reach_wait_ts", n, 0);
      reset_n = 1'b0;
      #1;
      check_reset("mid_rst");
      m_id = '0; m_ts = '0;
      q0.delete(); q1.delete();
      repeat (2) @(posedge clock);
      #2;
      push(0, 1, 1, EXP_ID); push(1, 0, 0, EXP_TS);
      run_seq(1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
